riscv_retire_monitor: RTL and testbench
=======================================

Name: riscv_retire_monitor

Overview:
CPU-side producer of the architectural observation interface: NUM_INST, OUTPUT_PORT and HALT. Instantiated inside the RISC-V top level and fed by the commit/writeback stage. Counts retired instructions, latches one observable result per retired instruction, and detects the halt idiom. Bench checkers sample its outputs on posedge CLK.

Parameters:
HALT_INST0, 32'h00c00093, first word of halt idiom (addi x1,x0,12)
HALT_INST1, 32'h00008067, second word of halt idiom (jalr x0,0(x1))
CNT_WIDTH, 32, width of the retired-instruction counter

Ports:
CLK  in  1  clock, all state on rising edge
RSTn  in  1  reset, synchronous, active-low
RETIRE_VALID  in  1  one-cycle pulse per committed instruction
RETIRE_INST  in  32  instruction word being committed
RF_WE  in  1  committed instruction writes register file
RF_WD  in  32  register write data
STORE_EN  in  1  committed instruction is a store
STORE_ADDR  in  12  store byte address
BR_EN  in  1  committed instruction is a conditional branch
BR_TAKEN  in  1  branch outcome
NUM_INST  out  CNT_WIDTH  retired-instruction count
OUTPUT_PORT  out  32  last observable result
HALT  out  1  sticky halt flag

Behaviour:
- Reset (RSTn low at posedge): NUM_INST=0, OUTPUT_PORT=0, HALT=0, FSM=IDLE. Reset mid-run clears everything in the same edge; reset wins over a coincident RETIRE_VALID.
- All outputs are registered; one cycle latency from the RETIRE_VALID edge to the visible update.
- Counter: on each accepted retire, NUM_INST+1. Saturates at all-ones with no wrap.
- OUTPUT_PORT updates only on an accepted retire, using this priority:
  - RF_WE: RF_WD.
  - else STORE_EN: {20'b0,STORE_ADDR}.
  - else BR_EN: {31'b0,BR_TAKEN}.
  - else hold the previous value.
- RF_WE/STORE_EN/BR_EN without RETIRE_VALID: ignored.
- Accepted retire means RETIRE_VALID=1 and HALT=0.
- Halt FSM, transitions evaluated only on accepted retire; otherwise hold state:
  - IDLE: RETIRE_INST==HALT_INST0 -> SEEN0; else stay IDLE.
  - SEEN0: RETIRE_INST==HALT_INST1 -> HALTED; RETIRE_INST==HALT_INST0 -> stay SEEN0; any other instruction -> IDLE.
  - HALTED: HALT=1, registered on the same edge that counts the jalr. Sticky until reset.
- The halting jalr is counted in NUM_INST and may update OUTPUT_PORT under the normal priority rules.
- After HALT, NUM_INST and OUTPUT_PORT are frozen and further retires are ignored.
- Cycles without a retire between the two halt words do not break the idiom.

Optional Feature:
- Macro: RETIRE_MONITOR_ERR_EN.
- Defined: adds output port ERR (out, 1). ERR is a sticky flag, cleared by reset. It sets on the edge after either condition:
  - an accepted retire with more than one of RF_WE/STORE_EN/BR_EN high;
  - any of RF_WE/STORE_EN/BR_EN high while RETIRE_VALID is low and HALT is low.
- ERR does not alter counting or OUTPUT_PORT behaviour.
- Undefined: no ERR port and no checking logic.

Test Plan:
- Three retires with RF_WE=1, RF_WD=5, 0, 1 on consecutive cycles -> NUM_INST reads 1, 2, 3; OUTPUT_PORT reads 5, 0, 1, each one cycle after its pulse.
- Retire with STORE_EN=1, STORE_ADDR=12'h3fc, then retire with BR_EN=1, BR_TAKEN=1, then retire with no flags -> OUTPUT_PORT = 0x3fc, then 0x1, then holds 0x1. NUM_INST advances by 3.
- Retire 0x00c00093 (RF_WE=1, RF_WD=12), two idle cycles, retire 0x00008067 -> HALT=1 one cycle after the jalr; NUM_INST=2; OUTPUT_PORT=12. Further retires leave NUM_INST=2.
- Retire 0x00c00093, then 0x00000013, then 0x00008067 -> HALT stays 0 (idiom broken). Retire 0x00c00093, 0x00c00093, 0x00008067 -> HALT=1.
- Force NUM_INST to all-ones via preload or long run, then retire -> NUM_INST stays all-ones. Assert RSTn=0 for one edge with RETIRE_VALID=1 -> all outputs 0.
- With RETIRE_MONITOR_ERR_EN: a retire with RF_WE=1 and STORE_EN=1 -> OUTPUT_PORT=RF_WD and ERR=1 sticky. Without the macro: same stimulus compiles with no ERR port and OUTPUT_PORT=RF_WD.

Source files
------------

// File: rtl/riscv_retire_monitor_if.sv
// Architectural observation bundle between the commit stage (master) and the retire monitor (slave).
// With RETIRE_MONITOR_ERR_EN defined, the bundle also carries the sticky ERR flag.
interface riscv_retire_monitor_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 RETIRE_VALID;
    logic [31:0]          RETIRE_INST;
    logic                 RF_WE;
    logic [31:0]          RF_WD;
    logic                 STORE_EN;
    logic [11:0]          STORE_ADDR;
    logic                 BR_EN;
    logic                 BR_TAKEN;
    logic [CNT_WIDTH-1:0] NUM_INST;
    logic [31:0]          OUTPUT_PORT;
    logic                 HALT;
`ifdef RETIRE_MONITOR_ERR_EN
    logic                 ERR;
`endif

    modport master (
        output RETIRE_VALID, RETIRE_INST, RF_WE, RF_WD, STORE_EN, STORE_ADDR, BR_EN, BR_TAKEN,
        input  NUM_INST, OUTPUT_PORT, HALT
`ifdef RETIRE_MONITOR_ERR_EN
        , input ERR
`endif
    );

    modport slave (
        input  RETIRE_VALID, RETIRE_INST, RF_WE, RF_WD, STORE_EN, STORE_ADDR, BR_EN, BR_TAKEN,
        output NUM_INST, OUTPUT_PORT, HALT
`ifdef RETIRE_MONITOR_ERR_EN
        , output ERR
`endif
    );
endinterface

// File: rtl/riscv_retire_monitor.sv
// Retire monitor: counts committed instructions, latches one observable result each, detects the halt idiom.
// With RETIRE_MONITOR_ERR_EN defined, adds a sticky ERR flag for malformed retire flag combinations.
module riscv_retire_monitor #(
    parameter logic [31:0] HALT_INST0 = 32'h00c00093,
    parameter logic [31:0] HALT_INST1 = 32'h00008067,
    parameter int          CNT_WIDTH  = 32
) (
    input logic                  CLK,
    input logic                  RSTn,
    riscv_retire_monitor_if.slave mon
);
    typedef enum logic [1:0] {
        IDLE,
        SEEN0,
        HALTED
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] count_next;
    logic [31:0]          result;
    logic [31:0]          result_next;
    logic                 accepted;

    assign accepted = mon.RETIRE_VALID && (state != HALTED);

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state  <= IDLE;
            count  <= '0;
            result <= '0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            result <= result_next;
        end
    end

    always_comb begin
        state_next  = state;
        count_next  = count;
        result_next = result;
        if (accepted) begin
            // Counter saturates rather than wrapping.
            if (count != '1) begin
                count_next = count + CNT_ONE;
            end
            if (mon.RF_WE) begin
                result_next = mon.RF_WD;
            end else if (mon.STORE_EN) begin
                result_next = {20'b0, mon.STORE_ADDR};
            end else if (mon.BR_EN) begin
                result_next = {31'b0, mon.BR_TAKEN};
            end
            case (state)
                IDLE: begin
                    if (mon.RETIRE_INST == HALT_INST0) begin
                        state_next = SEEN0;
                    end
                end
                SEEN0: begin
                    if (mon.RETIRE_INST == HALT_INST1) begin
                        state_next = HALTED;
                    end else if (mon.RETIRE_INST != HALT_INST0) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    assign mon.NUM_INST    = count;
    assign mon.OUTPUT_PORT = result;
    assign mon.HALT        = (state == HALTED);

`ifdef RETIRE_MONITOR_ERR_EN
    logic err;
    logic multi_flag;
    logic any_flag;

    assign multi_flag = (mon.RF_WE & mon.STORE_EN) | (mon.RF_WE & mon.BR_EN) | (mon.STORE_EN & mon.BR_EN);
    assign any_flag   = mon.RF_WE | mon.STORE_EN | mon.BR_EN;

    // Flags are only meaningful alongside a retire; stray ones while running are also errors.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            err <= 1'b0;
        end else if ((accepted && multi_flag) || (!mon.RETIRE_VALID && (state != HALTED) && any_flag)) begin
            err <= 1'b1;
        end
    end

    assign mon.ERR = err;
`endif
endmodule

// File: tb/tb_riscv_retire_monitor.sv
// Self-checking bench for riscv_retire_monitor: directed test-plan cases plus randomized traffic against a behavioural model.
// A second instance with a 4-bit counter exercises saturation within a short run.
module tb_riscv_retire_monitor;
    localparam logic [31:0] I0  = 32'h00c00093;
    localparam logic [31:0] I1  = 32'h00008067;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        CLK;
    logic        RSTn;
    logic        retire_valid;
    logic [31:0] retire_inst;
    logic        rf_we;
    logic [31:0] rf_wd;
    logic        store_en;
    logic [11:0] store_addr;
    logic        br_en;
    logic        br_taken;

    int checks = 0;
    int errors = 0;
    bit cmpEn  = 0;

    riscv_retire_monitor_if #(.CNT_WIDTH(32)) ifc ();
    riscv_retire_monitor_if #(.CNT_WIDTH(4))  ifs ();

    assign ifc.RETIRE_VALID = retire_valid;
    assign ifc.RETIRE_INST  = retire_inst;
    assign ifc.RF_WE        = rf_we;
    assign ifc.RF_WD        = rf_wd;
    assign ifc.STORE_EN     = store_en;
    assign ifc.STORE_ADDR   = store_addr;
    assign ifc.BR_EN        = br_en;
    assign ifc.BR_TAKEN     = br_taken;
    assign ifs.RETIRE_VALID = retire_valid;
    assign ifs.RETIRE_INST  = retire_inst;
    assign ifs.RF_WE        = rf_we;
    assign ifs.RF_WD        = rf_wd;
    assign ifs.STORE_EN     = store_en;
    assign ifs.STORE_ADDR   = store_addr;
    assign ifs.BR_EN        = br_en;
    assign ifs.BR_TAKEN     = br_taken;

    riscv_retire_monitor #(.CNT_WIDTH(32)) dut (.CLK(CLK), .RSTn(RSTn), .mon(ifc));
    riscv_retire_monitor #(.CNT_WIDTH(4))  dut_small (.CLK(CLK), .RSTn(RSTn), .mon(ifs));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Behavioural model: what the spec says the outputs become after each edge.
    logic [31:0] m_count;
    logic [3:0]  m_count_s;
    logic [31:0] m_out;
    logic        m_halt;
    logic        m_last_i0;
    logic        m_err;

    always @(posedge CLK) begin
        int nflags;
        bit acc;
        nflags = int'(rf_we) + int'(store_en) + int'(br_en);
        acc    = retire_valid && !m_halt;
        if (!RSTn) begin
            m_count   = 0;
            m_count_s = 0;
            m_out     = 0;
            m_halt    = 0;
            m_last_i0 = 0;
            m_err     = 0;
        end else begin
            if ((acc && nflags > 1) || (!retire_valid && !m_halt && nflags > 0)) m_err = 1;
            if (acc) begin
                if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
                if (m_count_s != 4'hF) m_count_s = m_count_s + 1;
                if (rf_we) m_out = rf_wd;
                else if (store_en) m_out = {20'b0, store_addr};
                else if (br_en) m_out = {31'b0, br_taken};
                if (m_last_i0 && retire_inst == I1) m_halt = 1;
                m_last_i0 = (retire_inst == I0);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) begin
        #1;
        if (cmpEn) begin
            checkOutput("model_num_inst", ifc.NUM_INST, m_count);
            checkOutput("model_output_port", ifc.OUTPUT_PORT, m_out);
            checkOutput("model_halt", {31'b0, ifc.HALT}, {31'b0, m_halt});
            checkOutput("model_num_inst_small", {28'b0, ifs.NUM_INST}, {28'b0, m_count_s});
            checkOutput("model_halt_small", {31'b0, ifs.HALT}, {31'b0, m_halt});
`ifdef RETIRE_MONITOR_ERR_EN
            checkOutput("model_err", {31'b0, ifc.ERR}, {31'b0, m_err});
`endif
        end
    end

    task automatic clearInputs();
        retire_valid = 0;
        retire_inst  = 0;
        rf_we        = 0;
        rf_wd        = 0;
        store_en     = 0;
        store_addr   = 0;
        br_en        = 0;
        br_taken     = 0;
    endtask

    task automatic applyStimulus(input logic [31:0] inst, input logic we, input logic [31:0] wd,
                                 input logic st, input logic [11:0] addr, input logic br, input logic tk);
        retire_valid = 1;
        retire_inst  = inst;
        rf_we        = we;
        rf_wd        = wd;
        store_en     = st;
        store_addr   = addr;
        br_en        = br;
        br_taken     = tk;
        @(negedge CLK);
        clearInputs();
    endtask

    task automatic idleCycles(input int n);
        clearInputs();
        repeat (n) @(negedge CLK);
    endtask

    task automatic doReset();
        clearInputs();
        RSTn = 0;
        @(negedge CLK);
        RSTn = 1;
    endtask

    initial begin
        clearInputs();
        RSTn = 0;
        repeat (2) @(negedge CLK);
        RSTn = 1;
        cmpEn = 1;
        checkOutput("reset_num_inst", ifc.NUM_INST, 0);
        checkOutput("reset_output_port", ifc.OUTPUT_PORT, 0);
        checkOutput("reset_halt", {31'b0, ifc.HALT}, 0);

        applyStimulus(NOP, 1, 5, 0, 0, 0, 0);
        checkOutput("rf_num1", ifc.NUM_INST, 1);
        checkOutput("rf_out5", ifc.OUTPUT_PORT, 5);
        applyStimulus(NOP, 1, 0, 0, 0, 0, 0);
        checkOutput("rf_num2", ifc.NUM_INST, 2);
        checkOutput("rf_out0", ifc.OUTPUT_PORT, 0);
        applyStimulus(NOP, 1, 1, 0, 0, 0, 0);
        checkOutput("rf_num3", ifc.NUM_INST, 3);
        checkOutput("rf_out1", ifc.OUTPUT_PORT, 1);

        applyStimulus(NOP, 0, 0, 1, 12'h3fc, 0, 0);
        checkOutput("store_out", ifc.OUTPUT_PORT, 32'h3fc);
        applyStimulus(NOP, 0, 0, 0, 0, 1, 1);
        checkOutput("branch_out", ifc.OUTPUT_PORT, 1);
        applyStimulus(NOP, 0, 0, 0, 0, 0, 0);
        checkOutput("hold_out", ifc.OUTPUT_PORT, 1);
        checkOutput("num_after_six", ifc.NUM_INST, 6);

        doReset();
        applyStimulus(I0, 1, 12, 0, 0, 0, 0);
        idleCycles(2);
        checkOutput("halt_not_yet", {31'b0, ifc.HALT}, 0);
        applyStimulus(I1, 0, 0, 0, 0, 0, 0);
        checkOutput("halt_set", {31'b0, ifc.HALT}, 1);
        checkOutput("halt_num", ifc.NUM_INST, 2);
        checkOutput("halt_out", ifc.OUTPUT_PORT, 12);
        applyStimulus(NOP, 1, 99, 0, 0, 0, 0);
        checkOutput("frozen_num", ifc.NUM_INST, 2);
        checkOutput("frozen_out", ifc.OUTPUT_PORT, 12);

        doReset();
        applyStimulus(I0, 0, 0, 0, 0, 0, 0);
        applyStimulus(NOP, 0, 0, 0, 0, 0, 0);
        applyStimulus(I1, 0, 0, 0, 0, 0, 0);
        checkOutput("idiom_broken", {31'b0, ifc.HALT}, 0);
        applyStimulus(I0, 0, 0, 0, 0, 0, 0);
        applyStimulus(I0, 0, 0, 0, 0, 0, 0);
        applyStimulus(I1, 0, 0, 0, 0, 0, 0);
        checkOutput("idiom_repeat_i0", {31'b0, ifc.HALT}, 1);
        checkOutput("idiom_num", ifc.NUM_INST, 6);

        doReset();
        for (int i = 0; i < 20; i++) applyStimulus(NOP, 0, 0, 0, 0, 0, 0);
        checkOutput("sat_small", {28'b0, ifs.NUM_INST}, 15);
        checkOutput("count_wide", ifc.NUM_INST, 20);
        applyStimulus(NOP, 0, 0, 0, 0, 0, 0);
        checkOutput("sat_small_hold", {28'b0, ifs.NUM_INST}, 15);

        RSTn = 0;
        retire_valid = 1;
        retire_inst  = NOP;
        rf_we        = 1;
        rf_wd        = 77;
        @(negedge CLK);
        RSTn = 1;
        clearInputs();
        checkOutput("rst_win_num", ifc.NUM_INST, 0);
        checkOutput("rst_win_out", ifc.OUTPUT_PORT, 0);
        checkOutput("rst_win_small", {28'b0, ifs.NUM_INST}, 0);

        applyStimulus(NOP, 1, 32'hABCD, 1, 12'h123, 0, 0);
        checkOutput("dual_flag_out", ifc.OUTPUT_PORT, 32'hABCD);
`ifdef RETIRE_MONITOR_ERR_EN
        checkOutput("err_set", {31'b0, ifc.ERR}, 1);
        idleCycles(2);
        checkOutput("err_sticky", {31'b0, ifc.ERR}, 1);
`endif

        for (int i = 0; i < 3000; i++) begin
            RSTn         = ($urandom_range(0, 49) != 0);
            retire_valid = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 7))
                0:       retire_inst = I0;
                1:       retire_inst = I1;
                2, 3, 4: retire_inst = NOP;
                default: retire_inst = $urandom;
            endcase
            rf_we      = retire_valid ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
            store_en   = retire_valid ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
            br_en      = retire_valid ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
            rf_wd      = $urandom;
            store_addr = 12'($urandom);
            br_taken   = $urandom_range(0, 1) == 1;
            @(negedge CLK);
        end
        clearInputs();
        RSTn = 1;
        @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
